timer_tick_gen: RTL and testbench

Programmable tick generator that produces the single-cycle `tick` enable consumed by the timer counter's `clk_pulse` input. It divides a source event stream (every `clk` cycle, or rising edges of an external clock) by a programmable ratio. It supports three run modes: continuous, one-shot and fixed-length burst. It sits between the timer register block, which drives start/stop/config, and one or more timer counters, which receive `tick`.

---
 rtl/timer_tick_gen.sv | 166 ++++++++++++++++
 tb/tb_timer_tick_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: programmable tick generator for the timer counters.
// Divides a source event stream by (div+1) and emits a one-cycle tick.
// Run modes: continuous, one-shot, and fixed-length burst.
// Optional feature macro: TIMER_TICK_EXT_EN compiles in the external-clock
// source path (synchronizer, edge detect, src_sel mux). Without it the
// source is always the internal clk, and src_sel/ext_clk are ignored.
module timer_tick_gen #(
  parameter int DIV_SIZE   = 16,
  parameter int BURST_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [DIV_SIZE-1:0]   div,
  input  logic [BURST_SIZE-1:0] burst_len,
  input  logic                  src_sel,
  input  logic                  ext_clk,
  output logic                  tick,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {
    M_CONT    = 2'b00,
    M_ONESHOT = 2'b01,
    M_BURST   = 2'b10,
    M_RSVD    = 2'b11
  } mode_e;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DIV_SIZE-1:0]   div_q, div_d;
  logic [DIV_SIZE-1:0]   pcnt_q, pcnt_d;
  logic [BURST_SIZE-1:0] burst_q, burst_d;
  logic [BURST_SIZE:0]   bcnt_q, bcnt_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;

  logic                  ev;
  logic [BURST_SIZE:0]   bcnt_inc;
  logic [BURST_SIZE:0]   burst_target;

`ifdef TIMER_TICK_EXT_EN
  logic       src_q, src_d;
  logic [2:0] sync_q, sync_d;

  // Two-stage synchronizer plus edge-detect stage; runs in every state.
  always_comb begin
    sync_d = {sync_q[1:0], ext_clk};
  end

  // Synchronizer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // Rising edge of the synchronized external clock, or every cycle when internal.
  assign ev = src_q ? (sync_q[1] & ~sync_q[2]) : 1'b1;
`else
  // The external source path is not built; its ports are deliberately unused.
  logic unused_ext;
  assign unused_ext = src_sel ^ ext_clk;
  assign ev         = 1'b1;
`endif

  // Burst length 0 stands for the full 2^BURST_SIZE ticks.
  assign burst_target = (burst_q == '0) ? {1'b1, {BURST_SIZE{1'b0}}}
                                        : {1'b0, burst_q};
  assign bcnt_inc     = bcnt_q + 1'b1;

  // Next-state, prescaler, burst counter and tick/done decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in combinational logic infers a latch.
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    burst_d = burst_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef TIMER_TICK_EXT_EN
    src_d   = src_q;
`endif
    if (stop) begin
      // stop overrides start and any tick that would be due this edge.
      state_d = S_IDLE;
      pcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            mode_d  = mode_e'(mode);
            div_d   = div;
            burst_d = burst_len;
            pcnt_d  = '0;
            bcnt_d  = '0;
`ifdef TIMER_TICK_EXT_EN
            src_d   = src_sel;
`endif
          end
        end
        S_RUN: begin
          if (ev) begin
            if (pcnt_q == div_q) begin
              tick_d = 1'b1;
              pcnt_d = '0;
              if (mode_q == M_BURST) bcnt_d = bcnt_inc;
              if ((mode_q == M_ONESHOT) ||
                  ((mode_q == M_BURST) && (bcnt_inc == burst_target))) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears all outputs asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_CONT;
      div_q   <= '0;
      burst_q <= '0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TIMER_TICK_EXT_EN
      src_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
`ifdef TIMER_TICK_EXT_EN
      src_q   <= src_d;
`endif
    end
  end

  assign tick = tick_q;
  assign done = done_q;
  assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_timer_tick_gen.sv
// Self-checking bench for timer_tick_gen: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against an event-counting model.
module tb_timer_tick_gen;

  localparam int DIV_SIZE   = 16;
  localparam int BURST_SIZE = 8;
`ifdef TIMER_TICK_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  stop;
  logic [1:0]            mode;
  logic [DIV_SIZE-1:0]   div;
  logic [BURST_SIZE-1:0] burst_len;
  logic                  src_sel;
  logic                  ext_clk;
  logic                  tick;
  logic                  busy;
  logic                  done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_tick_gen #(.DIV_SIZE(DIV_SIZE), .BURST_SIZE(BURST_SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .src_sel   (src_sel),
    .ext_clk   (ext_clk),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic                  start;
    logic                  stop;
    logic [1:0]            mode;
    logic [DIV_SIZE-1:0]   div;
    logic [BURST_SIZE-1:0] bl;
    logic                  tick;
    logic                  busy;
    logic                  done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; mode = 2'b00; div = '0;
    burst_len = '0; src_sel = 1'b0; ext_clk = 1'b0;
  endtask

  function automatic void add(input logic st, input logic sp, input logic [1:0] m,
                              input int d, input int b,
                              input logic t, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = m;
    v.div = DIV_SIZE'(d); v.bl = BURST_SIZE'(b);
    v.tick = t; v.busy = bz; v.done = dn;
    vecs.push_back(v);
  endfunction

  // Watchdog: the bench has no unbounded waits, this only guards the simulator.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reference-model state for the randomized phase.
    bit m_run;
    int m_div, m_mode, m_target, m_evs, m_ticks;
    bit e_tick, e_done;
    int ev_cnt;
    bit ev, exp_t;
    logic ext_hist[0:80];

    // ---------------- Directed vector table ----------------
    // Continuous div=3: ticks after edges 4, 8, 12; stop at edge 13.
    add(1, 0, 0, 3, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) add(0, 0, 0, 3, 0, (i % 4 == 0), 1, 0);
    add(0, 1, 0, 3, 0, 0, 0, 0);
    add(0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 0, 0, 3, 0, 0, 0, 0);
    // One-shot div=0, start held during RUN: one tick with done, busy drops.
    add(1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Burst length 3, div=1: ticks after edges 2, 4, 6; done with the third.
    add(1, 0, 2, 1, 3, 0, 1, 0);
    for (int i = 1; i <= 6; i++) add(0, 0, 2, 1, 3, (i % 2 == 0), (i < 6), (i == 6));
    add(0, 0, 2, 1, 3, 0, 0, 0);
    // Burst length 1, div=0: single tick with done.
    add(1, 0, 2, 0, 1, 0, 1, 0);
    add(0, 0, 2, 0, 1, 1, 0, 1);
    add(0, 0, 2, 0, 1, 0, 0, 0);
    // start and stop together in IDLE: stays idle.
    add(1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 0, 0);
    // One-shot div=2, stop on the edge where the tick is due.
    add(1, 0, 1, 2, 0, 0, 1, 0);
    add(0, 0, 1, 2, 0, 0, 1, 0);
    add(0, 0, 1, 2, 0, 0, 1, 0);
    add(0, 1, 1, 2, 0, 0, 0, 0);
    add(0, 0, 1, 2, 0, 0, 0, 0);
    // Reserved mode acts as continuous; div=0 holds tick high.
    add(1, 0, 3, 0, 0, 0, 1, 0);
    add(0, 0, 3, 0, 0, 1, 1, 0);
    add(0, 0, 3, 0, 0, 1, 1, 0);
    add(0, 0, 3, 0, 0, 1, 1, 0);
    add(0, 1, 3, 0, 0, 0, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0, 0);

    // ---------------- Reset state ----------------
    rst = 1'b1;
    idle_inputs();
    #12;
    check("reset_outputs", {tick, busy, done}, 3'b000);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("after_reset_idle", {tick, busy, done}, 3'b000);

    // ---------------- Apply the table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
      div = vecs[i].div; burst_len = vecs[i].bl;
      cycle();
      check($sformatf("vec%0d", i), {tick, busy, done},
            {vecs[i].tick, vecs[i].busy, vecs[i].done});
    end
    idle_inputs();

    // ---------------- Reset mid continuous run, div=4 ----------------
    start = 1'b1; mode = 2'b00; div = 16'd4;
    cycle();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) cycle();
    check("rst_run_tick_before", {tick, busy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {tick, busy, done}, 3'b000);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("rst_no_tick_after", {tick, busy, done}, 3'b000);
    end

    // ---------------- Burst length 0 (256 ticks), div=0 ----------------
    start = 1'b1; mode = 2'b10; div = '0; burst_len = '0;
    cycle();
    start = 1'b0;
    check("burst256_busy", busy, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      cycle();
      check($sformatf("burst256_c%0d", i), {tick, busy, done},
            {1'(i <= 256), 1'(i < 256), 1'(i == 256)});
    end

    // ---------------- Source select: external edges, div=1 ----------------
    // ext_clk period is 10 clk. With the external path built, an event reaches
    // the tick register 2 edges after the edge that first samples ext_clk high.
    // Without it the source is internal and ticks come every 2 clk.
    idle_inputs();
    for (int i = 0; i <= 80; i++) ext_hist[i] = 1'b0;
    start = 1'b1; mode = 2'b00; div = 16'd1; src_sel = 1'b1;
    cycle();
    start = 1'b0;
    ev_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      ext_clk = ((n % 10) >= 5);
      ext_hist[n] = ext_clk;
      cycle();
      if (EXT_EN) ev = (n >= 3) && ext_hist[n-2] && !ext_hist[n-3];
      else        ev = 1'b1;
      exp_t = 1'b0;
      if (ev) begin
        ev_cnt++;
        exp_t = (ev_cnt % 2 == 0);
      end
      check($sformatf("src_c%0d", n), {tick, busy}, {exp_t, 1'b1});
    end
    stop = 1'b1;
    cycle();
    check("src_stop", {tick, busy, done}, 3'b000);
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();

    // ---------------- Randomized run against the event-counting model ----------------
    m_run = 1'b0; m_div = 0; m_mode = 0; m_target = 0; m_evs = 0; m_ticks = 0;
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(0, 99) < 25);
      stop      = ($urandom_range(0, 99) < 3);
      mode      = 2'($urandom);
      div       = DIV_SIZE'($urandom_range(0, 5));
      burst_len = ($urandom_range(0, 19) == 0) ? '0 : BURST_SIZE'($urandom_range(1, 6));
      src_sel   = EXT_EN ? 1'b0 : 1'($urandom);
      e_tick = 1'b0;
      e_done = 1'b0;
      if (stop) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (start) begin
          m_run    = 1'b1;
          m_div    = int'(div);
          m_mode   = int'(mode);
          m_target = (burst_len == 0) ? (1 << BURST_SIZE) : int'(burst_len);
          m_evs    = 0;
          m_ticks  = 0;
        end
      end else begin
        m_evs++;
        if (m_evs % (m_div + 1) == 0) begin
          e_tick = 1'b1;
          m_ticks++;
          if (m_mode == 1 || (m_mode == 2 && m_ticks == m_target)) begin
            e_done = 1'b1;
            m_run  = 1'b0;
          end
        end
      end
      cycle();
      check($sformatf("rand_c%0d", c), {tick, busy, done}, {e_tick, m_run, e_done});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
